// File: rtl/spi_byte_tx.sv
// SPI mode-0 master transmitter: one byte per cs-low frame, MSB first, with a
// guaranteed cs-high gap after each frame so the display can latch the character.
module spi_byte_tx #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       sck,
  output logic       mosi,
  output logic       cs
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int GAP_W = $clog2(CS_GAP) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t           state, state_nxt;
  // bit 7 goes straight to mosi at accept, so only bits 6..0 need storing
  logic [6:0]       shreg, shreg_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
  logic             sck_nxt, mosi_nxt, cs_nxt, done_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      gap_cnt <= '0;
      sck     <= 1'b0;
      mosi    <= 1'b0;
      cs      <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      div_cnt <= div_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
      sck     <= sck_nxt;
      mosi    <= mosi_nxt;
      cs      <= cs_nxt;
      done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    div_cnt_nxt = div_cnt;
    gap_cnt_nxt = gap_cnt;
    sck_nxt     = sck;
    mosi_nxt    = mosi;
    cs_nxt      = cs;
    done_nxt    = 1'b0;

    case (state)
      S_IDLE: begin
        if (tx_valid) begin
          shreg_nxt   = tx_data[6:0];
          mosi_nxt    = tx_data[7];
          cs_nxt      = 1'b0;
          div_cnt_nxt = '0;
          bit_cnt_nxt = '0;
          state_nxt   = S_SETUP;
        end
      end

      S_SETUP: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nxt = '0;
          sck_nxt     = 1'b1;
          state_nxt   = S_SHIFT;
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end

      // sck phase is read from the sck register itself; data moves on falling edges
      S_SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nxt = '0;
          sck_nxt     = ~sck;
          if (sck) begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state_nxt = S_HOLD;
            end else begin
              mosi_nxt  = shreg[6];
              shreg_nxt = {shreg[5:0], 1'b0};
            end
          end
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end

      S_HOLD: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nxt = '0;
          cs_nxt      = 1'b1;
          done_nxt    = 1'b1;
          mosi_nxt    = 1'b0;
          gap_cnt_nxt = '0;
          state_nxt   = S_GAP;
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end

      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_cnt_nxt = '0;
          state_nxt   = S_IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + GAP_W'(1);
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  assign tx_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_spi_byte_tx.sv
// Bench for spi_byte_tx: two instances (CLK_DIV=4/CS_GAP=8 and CLK_DIV=1/CS_GAP=1)
// checked cycle by cycle against arithmetic frame timing and a display-side receiver model.
module tb_spi_byte_tx;

  localparam int DV[2] = '{4, 1};
  localparam int GP[2] = '{8, 1};

  logic       clk;
  logic       rst_n;
  logic [7:0] data[2];
  logic       valid[2];
  logic       ready[2], busy[2], done[2], sck[2], mosi[2], cs[2];

  int checks = 0;
  int errors = 0;

  spi_byte_tx #(.CLK_DIV(4), .CS_GAP(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(data[0]), .tx_valid(valid[0]),
    .tx_ready(ready[0]), .busy(busy[0]), .done(done[0]),
    .sck(sck[0]), .mosi(mosi[0]), .cs(cs[0])
  );

  spi_byte_tx #(.CLK_DIV(1), .CS_GAP(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_data(data[1]), .tx_valid(valid[1]),
    .tx_ready(ready[1]), .busy(busy[1]), .done(done[1]),
    .sck(sck[1]), .mosi(mosi[1]), .cs(cs[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Display receiver model: shift mosi on sck rise while cs low, latch on cs rise
  logic [7:0] rx_sh[2];
  int         rx_bits[2]   = '{0, 0};
  int         last_bits[2] = '{0, 0};
  int         done_cnt[2]  = '{0, 0};
  int         rx_total[2]  = '{0, 0};
  int         sck_bad      = 0;
  logic       prev_cs[2]   = '{1'b1, 1'b1};
  logic       prev_sck[2]  = '{1'b0, 1'b0};
  logic [7:0] rx_q0[$];
  logic [7:0] rx_q1[$];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (done[i]) done_cnt[i]++;
      if (cs[i] !== prev_cs[i] && sck[i] !== 1'b0) sck_bad++;
      if (!prev_sck[i] && sck[i] && !cs[i]) begin
        rx_sh[i] = {rx_sh[i][6:0], mosi[i]};
        rx_bits[i]++;
      end
      if (prev_cs[i] && !cs[i]) rx_bits[i] = 0;
      if (!prev_cs[i] && cs[i]) begin
        last_bits[i] = rx_bits[i];
        if (rx_bits[i] == 8) begin
          rx_total[i]++;
          if (i == 0) rx_q0.push_back(rx_sh[i]);
          else        rx_q1.push_back(rx_sh[i]);
        end
      end
      prev_cs[i]  = cs[i];
      prev_sck[i] = sck[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_rx(input int s, input logic [7:0] exp);
    logic [7:0] got;
    int         sz;
    sz = (s == 0) ? rx_q0.size() : rx_q1.size();
    check("rx_count", sz, 1);
    if (sz > 0) begin
      got = (s == 0) ? rx_q0.pop_front() : rx_q1.pop_front();
      check("rx_byte", got, exp);
    end
  endtask

  // Caller is at a negedge with valid[s]=1 and data[s]=b; the accept edge is the next posedge.
  task automatic frame(input int s, input logic [7:0] b, input bit keep,
                       input logic [7:0] nxt, input bit poke);
    int d, g, n, u, k, d0;
    logic cs_e, sck_e, mosi_e, done_e, rdy_e;
    d  = DV[s];
    g  = GP[s];
    n  = 1 + 17 * d + g;
    d0 = done_cnt[s];
    check("ready_pre", ready[s], 1);
    @(posedge clk);
    for (int t = 1; t <= n; t++) begin
      @(negedge clk);
      cs_e  = !(t <= 17 * d);
      u     = t - 1 - d;
      sck_e = (u >= 0) && (u < 16 * d) && (((u / d) % 2) == 0);
      k     = (t - 1) / (2 * d);
      if (k > 7) k = 7;
      mosi_e = cs_e ? 1'b0 : b[7 - k];
      done_e = (t == 1 + 17 * d);
      rdy_e  = (t == n);
      check("cs", cs[s], cs_e);
      check("sck", sck[s], sck_e);
      check("mosi", mosi[s], mosi_e);
      check("done", done[s], done_e);
      check("tx_ready", ready[s], rdy_e);
      check("busy", busy[s], !rdy_e);
      if (t == 1) begin
        valid[s] = keep;
        data[s]  = keep ? nxt : 8'($urandom);
      end
      if (poke && t == 5 * d) begin
        valid[s] = 1'b1;
        data[s]  = 8'h55;
      end
      if (poke && t == 5 * d + 1) valid[s] = 1'b0;
    end
    check("done_pulses", done_cnt[s] - d0, 1);
    check("sck_rises", last_bits[s], 8);
    pop_rx(s, b);
  endtask

  task automatic idle(input int s, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("idle_cs", cs[s], 1);
      check("idle_ready", ready[s], 1);
    end
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] hello[5];
    int         s, d0, t0;
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    rst_n = 1'b0;
    valid = '{1'b0, 1'b0};
    data  = '{8'h00, 8'h00};
    #12;
    for (int i = 0; i < 2; i++) begin
      check("rst_cs", cs[i], 1);
      check("rst_sck", sck[i], 0);
      check("rst_mosi", mosi[i], 0);
      check("rst_done", done[i], 0);
      check("rst_ready", ready[i], 1);
      check("rst_busy", busy[i], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single byte, then busy-time poke that must be ignored
    valid[0] = 1'b1; data[0] = 8'h41;
    frame(0, 8'h41, 1'b0, 8'h00, 1'b0);
    idle(0, 3);
    valid[0] = 1'b1; data[0] = 8'hC3;
    frame(0, 8'hC3, 1'b0, 8'h00, 1'b1);
    idle(0, 40);

    // tx_valid held: back-to-back frames
    valid[0] = 1'b1; data[0] = 8'h48;
    frame(0, 8'h48, 1'b1, 8'h69, 1'b0);
    frame(0, 8'h69, 1'b0, 8'h00, 1'b0);
    idle(0, 2);

    // reset during bit 3 of 0xFF
    d0 = done_cnt[0];
    t0 = rx_total[0];
    valid[0] = 1'b1; data[0] = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (7 * DV[0]) @(negedge clk);
    check("pre_rst_cs", cs[0], 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cs", cs[0], 1);
    check("mid_rst_sck", sck[0], 0);
    check("mid_rst_mosi", mosi[0], 0);
    check("mid_rst_done", done[0], 0);
    check("mid_rst_ready", ready[0], 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(0, 80);
    check("rst_no_done", done_cnt[0] - d0, 0);
    check("rst_no_rx", rx_total[0] - t0, 0);
    valid[0] = 1'b1; data[0] = 8'h0F;
    frame(0, 8'h0F, 1'b0, 8'h00, 1'b0);

    // CLK_DIV=1 instance
    valid[1] = 1'b1; data[1] = 8'hA5;
    frame(1, 8'hA5, 1'b0, 8'h00, 1'b0);
    idle(1, 2);

    // loopback string, back-to-back
    t0 = rx_total[1];
    valid[1] = 1'b1; data[1] = hello[0];
    for (int i = 0; i < 5; i++)
      frame(1, hello[i], (i < 4), (i < 4) ? hello[(i + 1) % 5] : 8'h00, 1'b0);
    check("hello_count", rx_total[1] - t0, 5);
    idle(1, 2);

    // randomized bytes on either instance
    for (int i = 0; i < 8; i++) begin
      s = int'($urandom_range(0, 1));
      b = 8'($urandom);
      valid[s] = 1'b1; data[s] = b;
      frame(s, b, 1'b0, 8'h00, ($urandom_range(0, 1) == 1));
      idle(s, 2);
    end

    check("sck_at_cs_change", sck_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_byte_tx.md
Name: spi_byte_tx

Overview:
- SPI mode-0 master transmitter: the host-side end of the display's SPI character link.
- Accepts ASCII bytes on a valid/ready handshake and frames each byte in its own cs low period, MSB first on mosi.
- The display receiver latches a character when cs rises, so every byte ends with a cs rising edge followed by a guaranteed gap.
- Sits in the host/test-harness design. Its sck/mosi/cs drive the display board's SPI pins directly.

Parameters:
- CLK_DIV, 4: clk cycles per sck half-period; legal range ≥1.
- CS_GAP, 8: clk cycles cs is held high after each byte before the next byte may be accepted; legal range ≥1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tx_data  input  8  byte to send (ASCII).
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  high only in IDLE; a transfer is accepted when tx_valid && tx_ready on a clk edge.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse in the cycle cs returns high.
- sck  output  1  SPI clock; idles low.
- mosi  output  1  SPI data, MSB first.
- cs  output  1  chip select, active low.

Behaviour:
- Reset (async assert, sync release): state=IDLE, cs=1, sck=0, mosi=0, done=0, busy=0, tx_ready=1. The shift register, bit counter and divider counter are cleared.
- Reset asserted mid-frame forces the reset values immediately. No done pulse is produced. The partial byte is discarded.
- All outputs are registered, except tx_ready and busy, which are decoded from the state register.
- Accept cycle T0:
  - tx_data is latched into the shift register.
  - The next state is SETUP.
  - At T0+1, cs=0 and mosi=bit7.
- SETUP: sck low for CLK_DIV cycles. Then enter SHIFT.
- SHIFT: 8 bits, each taking 2*CLK_DIV cycles.
  - sck high for CLK_DIV cycles, then low for CLK_DIV cycles.
  - The sck rising edge for bit k (k=0 for bit7) occurs at T0+1+CLK_DIV+2k*CLK_DIV.
  - mosi updates only at sck falling edges, to the next lower bit, so it is stable for CLK_DIV cycles on either side of each rising edge.
  - After the 8th falling edge, mosi holds bit0 and the state goes to HOLD.
- HOLD: sck low, cs low for CLK_DIV cycles. Then cs=1 and done=1 for one cycle, at T0+1+17*CLK_DIV.
- GAP: cs high, mosi=0, sck=0 for CS_GAP cycles. Then IDLE.
  - tx_ready rises at T0+1+17*CLK_DIV+CS_GAP.
- tx_data and tx_valid are ignored while busy. tx_data may change after the accept cycle without affecting the frame.
- If tx_valid is held high continuously, bytes go back-to-back with exactly CS_GAP high cycles between frames, plus the one accept cycle in IDLE.
- Exactly 8 sck rising edges per frame, all inside cs low. sck is never high when cs changes.
- Counter widths: divider uses $clog2(CLK_DIV)+1 bits; gap counter uses $clog2(CS_GAP)+1 bits; bit counter is 3 bits and wraps at 7 to end SHIFT.
- CLK_DIV=1 is legal: sck toggles every clk cycle and frame length is 17 cycles from cs fall to cs rise.

Test Plan:
- CLK_DIV=4, CS_GAP=8, send 0x41:
  - mosi sampled at the 8 sck rises = 0,1,0,0,0,0,0,1.
  - cs low for exactly 68 cycles (T0+1..T0+68).
  - done pulses at T0+69.
  - tx_ready high again at T0+77.
- tx_valid held high with 0x48 then 0x69:
  - two frames decode 0x48, 0x69.
  - cs high for exactly CS_GAP+1=9 cycles between frames.
  - exactly 2 done pulses.
- Pulse tx_valid with 0x55 while busy mid-frame: ignored; the current frame completes unchanged and no extra frame is sent.
- Assert rst_n low during bit 3 of 0xFF:
  - cs=1, sck=0, mosi=0 in the same cycle.
  - no done pulse.
  - the next accepted byte 0x0F transmits correctly.
- CLK_DIV=1, CS_GAP=1, send 0xA5: sck period 2 cycles, bits 1,0,1,0,0,1,0,1, cs low for 17 cycles.
- Loopback into the display's SPI receiver, sending "HELLO": the receiver reports 5 completed bytes equal to 0x48,0x45,0x4C,0x4C,0x4F.
